// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// work layout (2*WIDTH+1 bits):
//   multiply: {partial product upper (WIDTH+1), multiplier being shifted out (WIDTH)}
//   divide:   {remainder (WIDTH+1), dividend shifting in / quotient shifting out (WIDTH)}
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH:0]   work_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   work_out,
  output logic               qbit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh_rem;
  logic [WIDTH:0] diff;
  logic           ge;

  // Quotient bit slot (work_out[0]) is left clear for divide; caller ORs in qbit.
  always_comb begin
    sum    = work_in[2*WIDTH:WIDTH] + (work_in[0] ? {1'b0, operand} : '0);
    sh_rem = {work_in[2*WIDTH-1:WIDTH], work_in[WIDTH-1]};
    diff   = sh_rem - {1'b0, operand};
    ge     = (sh_rem >= {1'b0, operand});
    qbit   = div & ge;
    if (div)
      work_out = {(ge ? diff : sh_rem), work_in[WIDTH-2:0], 1'b0};
    else
      work_out = {1'b0, sum, work_in[WIDTH-1:1]};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one iteration per cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state, state_nx;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q, opd;
  logic [2*WIDTH:0]   work, step_work;
  logic [CW-1:0]      cnt;
  logic               sign_q, sign_r, dz_q, step_q;
  logic               is_div, is_signed, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign b_zero    = (b_q == '0);
  // Magnitudes fit in WIDTH bits unsigned, including |MIN| = 2^(WIDTH-1).
  assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Sign correction of the final magnitudes; negation wraps, so MIN/-1 gives MIN.
  always_comb begin
    prod_fix = sign_q ? -work[2*WIDTH-1:0] : work[2*WIDTH-1:0];
    quo_fix  = sign_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    rem_fix  = sign_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div      (is_div),
    .work_in  (work),
    .operand  (opd),
    .work_out (step_work),
    .qbit     (step_q)
  );

  assign busy     = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  assign done     = (state == S_DONE);
  assign div_zero = done & dz_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_PREP;
      S_PREP: state_nx = (is_div && b_zero) ? S_DONE : S_CALC;
      S_CALC: if (cnt == CW'(WIDTH - 1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = start ? S_PREP : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and HI/LO; MTHI/MTLO only when idle, results land on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_MULTU;
      a_q    <= '0;
      b_q    <= '0;
      opd    <= '0;
      work   <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz_q   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q <= op_t'(op);
            a_q  <= a;
            b_q  <= b;
          end
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
        end
        S_PREP: begin
          sign_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_r <= is_signed & a_q[WIDTH-1];
          cnt    <= '0;
          work   <= {{(WIDTH+1){1'b0}}, (is_div ? mag_a : mag_b)};
          opd    <= is_div ? mag_b : mag_a;
          dz_q   <= is_div & b_zero;
          if (is_div && b_zero) begin
            lo <= '1;
            hi <= a_q;
          end
        end
        S_CALC: begin
          work <= step_work | {{(2*WIDTH){1'b0}}, step_q};
          cnt  <= cnt + 1'b1;
        end
        S_FIX: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            lo <= prod_fix[WIDTH-1:0];
            hi <= prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + randomized bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [W-1:0]  a_i = '0, b_i = '0, wdata = '0;
  logic          hi_we = 1'b0, lo_we = 1'b0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(W), .CW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS results from plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint unsigned up;
    longint          sp, sx, sy, q, r;
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin up = {32'b0, x} * {32'b0, y}; h = up[63:32]; l = up[31:0]; end
      2'b01: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        h = sp[63:32]; l = sp[31:0];
      end
      default: begin
        if (y == 0) begin
          z = 1'b1; l = '1; h = x;
        end else if (o == 2'b10) begin
          l = x / y; h = x % y;
        end else begin
          sx = longint'($signed(x)); sy = longint'($signed(y));
          q = sx / sy; r = sx % sy;
          l = q[31:0]; h = r[31:0];
        end
      end
    endcase
  endfunction

  // From the negedge after the start edge, walk until done; n counts edges after the start edge.
  task automatic wait_done(input string tag, input int n0, input logic dz_exp);
    int n = n0, bcnt = n0;
    logic leak = 1'b0;
    while (!done && n < 200) begin
      if (busy) bcnt++;
      if (div_zero) leak = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(n), dz_exp ? 32'd1 : 32'(W + 2));
    chk({tag, " busy cycles"}, 32'(bcnt), dz_exp ? 32'd1 : 32'(W + 2));
    chk({tag, " dz low while not done"}, 32'(leak), 32'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op_i = o; a_i = x; b_i = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] eh, el;
    logic ez;
    model(o, x, y, eh, el, ez);
    issue(o, x, y);
    wait_done(tag, 0, ez);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    chk({tag, " div_zero"}, 32'(div_zero), 32'(ez));
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    int           sel;

    // Reset state
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset dz", 32'(div_zero), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op("multu max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu max hi const", hi, 32'hFFFFFFFE);
    chk("multu max lo const", lo, 32'h00000001);
    @(negedge clk);
    chk("done one cycle", 32'(done), 32'd0);
    do_op("mult -3*5", 2'b01, 32'hFFFFFFFD, 32'd5);
    chk("mult lo const", lo, 32'hFFFFFFF1);
    do_op("div -7/2", 2'b11, 32'hFFFFFFF9, 32'd2);
    chk("div lo const", lo, 32'hFFFFFFFD);
    chk("div hi const", hi, 32'hFFFFFFFF);
    do_op("divu by zero", 2'b10, 32'h1234, 32'd0);
    chk("dz hi const", hi, 32'h1234);
    chk("dz flag const", 32'(div_zero), 32'd1);
    @(negedge clk);
    chk("dz flag clears", 32'(div_zero), 32'd0);
    do_op("div min/-1", 2'b11, 32'h80000000, 32'hFFFFFFFF);
    chk("min/-1 lo const", lo, 32'h80000000);

    // start + MTHI while busy are ignored
    issue(2'b00, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    op_i = 2'b11; a_i = 32'd100; b_i = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done("ignored start", 5, 1'b0);
    chk("ignored hi", hi, 32'd0);
    chk("ignored lo", lo, 32'd42);
    @(negedge clk);
    chk("done pulse ends", 32'(done), 32'd0);
    hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi idle", hi, 32'hAA);
    lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo idle", lo, 32'h55);

    // Async reset mid-CALC
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst hi", hi, 32'd0);
    chk("async rst lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op("divu 100/7", 2'b10, 32'd100, 32'd7);
    chk("divu 100/7 lo const", lo, 32'd14);

    // Back-to-back: next start issued in the done cycle
    do_op("b2b first", 2'b00, 32'd2, 32'd3);
    do_op("b2b second", 2'b10, 32'd9, 32'd4);
    chk("b2b second lo const", lo, 32'd2);
    chk("b2b second hi const", hi, 32'd1);

    // MTLO on the same edge as start is overwritten by the result
    lo_we = 1'b1; wdata = 32'hDEAD;
    issue(2'b01, 32'd4, 32'd5);
    lo_we = 1'b0;
    wait_done("mtlo with start", 0, 1'b0);
    chk("mtlo with start lo", lo, 32'd20);

    // Randomized operations, biased toward sign boundaries and zero divisors
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = '0;
      if (sel == 1) ra = 32'h80000000;
      if (sel == 2) rb = 32'hFFFFFFFF;
      if (sel == 3) rb = rb >> $urandom_range(8, 28);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      do_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
